// File: rtl/loadreg_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin load/clear register arbiter.
package loadreg_rr_arbiter_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Pointer starts at the last requester so requester 0 is searched first.
    function automatic int unsigned ptr_rst(input int unsigned nreq);
        return nreq - 1;
    endfunction

endpackage

// File: rtl/loadreg_rr_arbiter_rr_picker.sv
// Combinational round-robin select: first set req bit after ptr, with wrap.
module loadreg_rr_arbiter_rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  idx,
    output logic [NREQ-1:0] onehot
);

    int c;

    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        c      = 0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            c = (int'(ptr) + k) % int'(NREQ);
            if (req[c]) begin
                valid  = 1'b1;
                idx    = IDW'(c);
                onehot = '0;
                onehot[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/loadreg_rr_arbiter.sv
// Round-robin arbiter that sequences one write (load or clear) into a shared
// register per grant, then reads it back and flags any mismatch.
module loadreg_rr_arbiter
    import loadreg_rr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         wr_clr,
    input  logic [NREQ*WIDTH-1:0]   wr_data,
    input  logic [WIDTH-1:0]        reg_Q,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    reg_load,
    output logic                    reg_clear_n,
    output logic [WIDTH-1:0]        reg_D,
    output logic [IDW-1:0]          owner,
    output logic                    busy,
    output logic                    err
);

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic               op_clr;
    logic [WIDTH-1:0]   data_q;
    logic               clr_n_q;

    logic               pick_valid;
    logic [IDW-1:0]     pick_idx;
    logic [NREQ-1:0]    pick_onehot;
    logic [WIDTH-1:0]   pick_data;
    logic               pick_clr;
    logic [WIDTH-1:0]   expected;

    loadreg_rr_arbiter_rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign pick_data = wr_data[int'(pick_idx)*int'(WIDTH) +: WIDTH];
    assign pick_clr  = wr_clr[pick_idx];
    assign expected  = op_clr ? '0 : data_q;

    // Reset also clears the shared register on the very same edge.
    assign reg_clear_n = clear & clr_n_q;

    always_ff @(posedge clk) begin
        if (!clear) begin
            state    <= ST_IDLE;
            ptr      <= IDW'(ptr_rst(NREQ));
            owner    <= '0;
            op_clr   <= 1'b0;
            data_q   <= '0;
            gnt      <= '0;
            ack      <= '0;
            reg_load <= 1'b0;
            clr_n_q  <= 1'b1;
            reg_D    <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= '0;
                    if (pick_valid) begin
                        state    <= ST_WRITE;
                        owner    <= pick_idx;
                        op_clr   <= pick_clr;
                        data_q   <= pick_data;
                        gnt      <= pick_onehot;
                        busy     <= 1'b1;
                        reg_load <= ~pick_clr;
                        clr_n_q  <= ~pick_clr;
                        reg_D    <= pick_clr ? '0 : pick_data;
                    end
                end
                ST_WRITE: begin
                    state    <= ST_CHECK;
                    reg_load <= 1'b0;
                    clr_n_q  <= 1'b1;
                    reg_D    <= '0;
                    ack      <= NREQ'(1) << owner;
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                    ack   <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= owner;
                    if (reg_Q != expected) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    gnt      <= '0;
                    ack      <= '0;
                    reg_load <= 1'b0;
                    clr_n_q  <= 1'b1;
                    reg_D    <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/loadreg_rr_arbiter.md
Name: loadreg_rr_arbiter

Overview:
Round-robin write arbiter and sequencer for one shared 8-bit synchronous load/clear register. Up to NREQ requesters each ask to load a value into the register or clear it. The arbiter grants one requester at a time, drives the register's load, clear and data inputs for exactly one cycle, then reads back the register output. It acknowledges the requester and flags any readback mismatch. It sits between requester blocks and the register instance, which lives outside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width of the shared register
IDW, $clog2(NREQ), width of owner index

Ports:
clk  input  1  clock, all logic on rising edge
clear  input  1  synchronous active-low reset
req  input  NREQ  per-requester write request; held high until matching ack
wr_clr  input  NREQ  per-requester op select; 1 = clear register, 0 = load wr_data slice
wr_data  input  NREQ*WIDTH  per-requester data; slice i is bits [i*WIDTH +: WIDTH]
reg_Q  input  WIDTH  readback from shared register output
gnt  output  NREQ  one-hot grant, high during WRITE and CHECK for the owner
ack  output  NREQ  one-cycle pulse to owner when its write has completed
reg_load  output  1  load enable to shared register
reg_clear_n  output  1  active-low synchronous clear to shared register
reg_D  output  WIDTH  data to shared register
owner  output  IDW  index of current or last granted requester
busy  output  1  high in WRITE and CHECK
err  output  1  sticky readback-mismatch flag

Behaviour:
- Reset: synchronous, sampled on rising clk while clear=0, and it wins over everything. State=IDLE. gnt=0, ack=0, reg_load=0, reg_D=0, busy=0, err=0, owner=0. Round-robin pointer ptr=NREQ-1, so requester 0 has first priority.
- While clear=0, reg_clear_n=0, so the shared register clears on the same edge.
- FSM states: IDLE, WRITE, CHECK. The encoding is a shared-package enum.
- IDLE:
  - If req is nonzero, pick the first set bit searching ptr+1, ptr+2, ... with wrap modulo NREQ.
  - Latch owner, op=wr_clr[owner] and data=wr_data slice. Set gnt one-hot and go to WRITE.
  - Otherwise stay in IDLE with all strobes low.
- WRITE (exactly 1 cycle):
  - Load op: reg_load=1, reg_D=latched data, reg_clear_n=1.
  - Clear op: reg_clear_n=0, reg_load=0, reg_D=0.
  - Go to CHECK.
- CHECK (exactly 1 cycle):
  - Expected value = latched data for load, 0 for clear. If reg_Q differs from expected, set err=1.
  - err stays set until reset.
  - Pulse ack[owner]=1, set ptr=owner, deassert gnt and go to IDLE.
- Latency: req sampled at edge t gives gnt at t+1, register update at edge t+2, ack high in cycle t+2..t+3. Peak throughput is one write per 3 cycles.
- Outputs are decoded from registered state and latched fields only. There is no combinational path from req or wr_* to any output.
- A requester dropping req during WRITE or CHECK does not abort the operation; the write completes and ack is still pulsed.
- If a requester keeps req high after ack, it is only re-eligible behind all other pending requesters, because the pointer has advanced.
- wr_clr and wr_data changes after grant are ignored; the latched copies are used.
- Simultaneous requests: strict rotation, so no requester waits more than NREQ-1 grants.
- Reset asserted in WRITE or CHECK: the next state is IDLE, no ack is issued, and the register is cleared.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WRITE, CHECK)
  - default NREQ and WIDTH constants
  - the pointer reset value
- One natural sub-module: rr_picker, a combinational one-hot round-robin select from req and ptr, producing a valid flag and an index.

Test Plan:
1. Reset: hold clear=0 for 2 cycles with req=1111 → gnt=0, ack=0, busy=0, reg_clear_n=0, err=0. After release, the first grant goes to requester 0.
2. Single load: req=0001, wr_clr=0, data0=0xA5 → gnt=0001 after 1 edge; next cycle reg_load=1 and reg_D=0xA5; then reg_Q=0xA5, ack=0001 for one cycle, err=0.
3. Round robin: req=1111 held, data_i=0x10+i, all loads, each req dropped after its ack → grant order 0,1,2,3. ack pulses 3 cycles apart; the final reg_Q=0x13.
4. Clear op: register holds 0xFF; req=0100 with wr_clr[2]=1 → reg_clear_n=0 for exactly one cycle, reg_load=0, reg_Q=0x00, ack=0100, err=0.
5. Mismatch: tie reg_Q=0x55 and load 0x3C from requester 1 → ack=0010 still pulses and err=1. err stays 1 through further writes until clear=0.
6. Reset mid-operation: assert clear=0 during WRITE of a 0x77 load → next cycle state IDLE, gnt=0, reg_load=0, no ack, reg_Q=0x00.
